// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, reset PC
// and the opcode field position.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_HOLD  = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam int          OP_HI            = 31;
   localparam int          OP_LO            = 26;

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Control-flow outcome: redirect on jump, or on a branch whose condition
// (beq: zero, bne: not zero) holds, qualified by the resolve strobe.
module branch_resolve (
   input  logic i_resolve_valid,
   input  logic i_jump,
   input  logic i_branch_en,
   input  logic i_branch_type,
   input  logic i_zero,
   output logic o_taken
);

   logic w_cond;

   assign w_cond  = i_branch_type ? i_zero : ~i_zero;
   assign o_taken = i_resolve_valid & (i_jump | (i_branch_en & w_cond));

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch with redirect handling.
// Optional macro FETCH_MISALIGN_TRAP_EN halts on a misaligned redirect target.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [5:0]  op,
   input  logic        resolve_valid,
   input  logic        jump,
   input  logic        branch_en,
   input  logic        branch_type,
   input  logic        zero,
   input  logic [31:0] target_pc,
   output logic        misalign_err
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_addr;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   logic        w_taken;
   logic        w_redirect;
   logic [31:0] w_tgt;

   branch_resolve u_resolve (
      .i_resolve_valid (resolve_valid),
      .i_jump          (jump),
      .i_branch_en     (branch_en),
      .i_branch_type   (branch_type),
      .i_zero          (zero),
      .o_taken         (w_taken)
   );

   assign w_tgt      = {target_pc[31:2], 2'b00};
   // Redirects only matter once the fetch stream is live
   assign w_redirect = w_taken && (r_state == S_FETCH || r_state == S_HOLD ||
                                   r_state == S_FLUSH);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_err;
   assign misalign_err = r_err;
`else
   logic w_unused;
   assign w_unused     = ^target_pc[1:0];
   assign misalign_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_err      <= 1'b0;
`endif
      end else if (w_redirect) begin
         r_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (target_pc[1:0] != 2'b00) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HALT;
         end else
`endif
         begin
            r_pc <= w_tgt;
            // An unacknowledged request must still complete at its old address
            if (r_state == S_HOLD || imem_ack) begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               r_addr  <= w_tgt;
            end else begin
               r_state <= S_FLUSH;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               r_addr  <= r_pc;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr    <= imem_rdata;
                  r_instr_pc <= r_pc;
                  r_pc       <= pc_incr(r_pc);
                  r_valid    <= 1'b1;
                  r_req      <= 1'b0;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
                  r_state <= S_FETCH;
               end
            end
            S_FLUSH: begin
               if (imem_ack) begin
                  r_addr  <= r_pc;
                  r_state <= S_FETCH;
               end
            end
            S_HALT: begin
               r_req <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign op          = r_instr[OP_HI:OP_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized traffic
// checked against an architectural PC-stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, instr_valid, instr_ready, misalign_err;
   logic        resolve_valid, jump, branch_en, branch_type, zero;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, target_pc;
   logic [5:0]  op;

   logic        reset2, req2, valid2, err2;
   logic [31:0] addr2, instr2, ipc2;
   logic [5:0]  op2;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .op(op),
      .resolve_valid(resolve_valid), .jump(jump), .branch_en(branch_en),
      .branch_type(branch_type), .zero(zero), .target_pc(target_pc),
      .misalign_err(misalign_err)
   );

   // Second instance: wrap of the PC at the top of the address space
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(req2), .imem_rdata(32'h1234_5678), .instr_valid(valid2),
      .instr_ready(1'b1), .instr(instr2), .instr_pc(ipc2), .op(op2),
      .resolve_valid(1'b0), .jump(1'b0), .branch_en(1'b0),
      .branch_type(1'b0), .zero(1'b0), .target_pc(32'h0),
      .misalign_err(err2)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } exp_t;

   exp_t        q[$];
   logic [31:0] d2_addrs[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_hs  = 0;
   logic [31:0] model_pc;
   int          dly = -1;
   int          ack_mode = 0;
   bit          p_pend = 0;
   logic [31:0] p_addr;
   bit          last_ack = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit taken_f();
      return resolve_valid && (jump || (branch_en && (branch_type ? zero : !zero)));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: answer memory, advance the model, move to the next negedge
   task automatic cycle();
      if (!reset && p_pend) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_held", imem_addr, p_addr);
      end
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
         if (dly < 0) dly = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
         if (dly == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            dly        = -1;
         end else dly--;
      end
      last_ack = imem_ack;
      p_pend   = !reset && imem_req && !imem_ack;
      p_addr   = imem_addr;
      if (!reset) begin
         if (taken_f()) model_pc = {target_pc[31:2], 2'b00};
         else if (instr_valid && instr_ready) begin
            q.push_back('{model_pc, mem_word(model_pc)});
            model_pc += 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0040_0000);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_err", 32'(misalign_err), 32'd0);
      q.delete();
      reset    = 1'b0;
      model_pc = 32'h0040_0000;
      p_pend   = 0;
      dly      = -1;
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 12 && !instr_valid; k++) cycle();
      chk("wait_valid", 32'(instr_valid), 32'd1);
   endtask

   // Monitor: every consumed instruction must match the model's next entry
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (reset === 1'b0 && instr_valid && instr_ready && !taken_f()) begin
            n_hs++;
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_empty: got pc %h with no expected entry", instr_pc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_pc", instr_pc, e.pc);
               chk("sb_instr", instr, e.w);
               chk("sb_op", 32'(op), 32'(e.w[31:26]));
            end
         end
      end
   end

   initial begin
      reset2 = 1'b1;
      repeat (2) @(negedge clk);
      reset2 = 1'b0;
      forever begin
         @(negedge clk);
         if (req2 && d2_addrs.size() < 2) d2_addrs.push_back(addr2);
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] addrs[$];
      logic [31:0] held, a_old;
      int          vcnt;

      reset = 1'b1;  instr_ready = 1'b1; resolve_valid = 1'b0; jump = 1'b0;
      branch_en = 1'b0; branch_type = 1'b0; zero = 1'b0; target_pc = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      @(negedge clk);
      do_reset();

      // Back-to-back fetch with immediate ack and ready
      ack_mode = 0;
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req) addrs.push_back(imem_addr);
         if (instr_valid) vcnt++;
         cycle();
      end
      chk("seq_len", 32'(addrs.size()), 32'd4);
      if (addrs.size() >= 3) begin
         chk("seq_a0", addrs[0], 32'h0040_0000);
         chk("seq_a1", addrs[1], 32'h0040_0004);
         chk("seq_a2", addrs[2], 32'h0040_0008);
      end
      chk("seq_valid_pulses", 32'(vcnt), 32'd3);

      // Stall from decode
      instr_ready = 1'b0;
      wait_valid();
      held = instr;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_instr", instr, held);
         chk("stall_req", 32'(imem_req), 32'd0);
      end

      // Taken beq while holding
      branch_en = 1'b1; branch_type = 1'b1; zero = 1'b1;
      target_pc = 32'h0040_0100; resolve_valid = 1'b1;
      cycle();
      resolve_valid = 1'b0;
      chk("beq_valid_drop", 32'(instr_valid), 32'd0);
      chk("beq_req", 32'(imem_req), 32'd1);
      chk("beq_addr", imem_addr, 32'h0040_0100);
      wait_valid();
      zero = 1'b0; target_pc = 32'h0040_0300; resolve_valid = 1'b1;
      cycle();
      resolve_valid = 1'b0; branch_en = 1'b0;
      chk("beq_nt_valid", 32'(instr_valid), 32'd1);
      chk("beq_nt_req", 32'(imem_req), 32'd0);
      instr_ready = 1'b1;

      // Redirect during a slow outstanding request
      ack_mode = 3;
      for (int k = 0; k < 6 && !(imem_req && dly < 0); k++) cycle();
      chk("flush_fresh_req", 32'(imem_req && dly < 0), 32'd1);
      a_old = imem_addr;
      jump = 1'b1; target_pc = 32'h0040_0200; resolve_valid = 1'b1;
      cycle();
      resolve_valid = 1'b0; jump = 1'b0;
      for (int k = 0; k < 8 && !last_ack; k++) begin
         chk("flush_old_addr", imem_addr, a_old);
         cycle();
      end
      chk("flush_acked", 32'(last_ack), 32'd1);
      chk("flush_new_req", 32'(imem_req), 32'd1);
      chk("flush_new_addr", imem_addr, 32'h0040_0200);
      ack_mode = 0;

      // Misaligned redirect
      instr_ready = 1'b0;
      wait_valid();
      jump = 1'b1; target_pc = 32'h0040_0102; resolve_valid = 1'b1;
      cycle();
      resolve_valid = 1'b0; jump = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("mis_no_req", 32'(imem_req), 32'd0);
         cycle();
      end
      instr_ready = 1'b1;
      do_reset();
`else
      chk("mis_err", 32'(misalign_err), 32'd0);
      chk("mis_req", 32'(imem_req), 32'd1);
      chk("mis_addr", imem_addr, 32'h0040_0100);
      instr_ready = 1'b1;
`endif

      // Randomized traffic
      ack_mode = -1;
      for (int i = 0; i < 1500; i++) begin
         instr_ready   = ($urandom_range(0, 9) < 7);
         resolve_valid = (imem_req || instr_valid) && ($urandom_range(0, 5) == 0);
         jump          = ($urandom_range(0, 3) == 0);
         branch_en     = $urandom_range(0, 1) == 1;
         branch_type   = $urandom_range(0, 1) == 1;
         zero          = $urandom_range(0, 1) == 1;
         target_pc     = 32'h0040_0000 + (32'($urandom_range(0, 255)) << 2);
`ifndef FETCH_MISALIGN_TRAP_EN
         target_pc     = target_pc + 32'($urandom_range(0, 3));
`endif
         cycle();
`ifndef FETCH_MISALIGN_TRAP_EN
         if (misalign_err !== 1'b0) chk("rand_err", 32'(misalign_err), 32'd0);
`endif
      end
      resolve_valid = 1'b0;
      instr_ready   = 1'b1;
      for (int i = 0; i < 10; i++) cycle();

      chk("sb_drained", 32'(q.size()), 32'd0);
      chk("hs_enough", 32'(n_hs > 200), 32'd1);
      chk("wrap_count", 32'(d2_addrs.size()), 32'd2);
      if (d2_addrs.size() == 2) begin
         chk("wrap_a0", d2_addrs[0], 32'hFFFF_FFFC);
         chk("wrap_a1", d2_addrs[1], 32'h0000_0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the word-aligned byte address fetched first after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of the requested word.
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 instr_valid  output  1  instr, instr_pc and op hold a fetched instruction.
REQ-009 instr_ready  input  1  decode stage consumes the instruction.
REQ-010 instr, instr_pc  output  32 each  fetched word and its address.
REQ-011 op  output  6  instr[31:26], feeding the control decoder.
REQ-012 resolve_valid  input  1  control outcome below is valid this cycle.
REQ-013 jump, branch_en, branch_type, zero  input  1 each  Jump, BranchEn, BranchType (1 beq, 0 bne), ALU zero flag.
REQ-014 target_pc  input  32  redirect address.
REQ-015 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-016 taken SHALL equal resolve_valid & (jump | (branch_en & (branch_type ? zero : ~zero))).
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD, FLUSH, HALT.
REQ-018 IDLE: outputs quiet; next cycle unconditionally FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=pc; without imem_ack, remain in FETCH, holding req and addr stable.
REQ-020 FETCH with imem_ack and no taken: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go HOLD.
REQ-021 HOLD: imem_req=0; instr_valid stays 1 until instr_ready; on instr_ready: instr_valid<=0, go FETCH. Throughput is one instruction per two cycles.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 taken in HOLD: instr_valid<=0, instr discarded (even if instr_ready), pc<=target_pc, go FETCH.
REQ-024 taken in FETCH without imem_ack: pc<=target_pc, go FLUSH; req stays high.
REQ-025 taken in FETCH with imem_ack: data discarded, pc<=target_pc, go FETCH.
REQ-026 FLUSH: imem_req=1 at old address until imem_ack; returned data discarded; then FETCH at pc.
REQ-027 taken SHALL take priority over instr_ready and imem_ack in the same cycle.
REQ-028 resolve_valid with taken=0 SHALL have no effect.
REQ-029 op SHALL be instr[31:26] combinationally from the instr register.

Reset
REQ-030 On reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, op=0, misalign_err=0.
REQ-031 reset asserted mid-fetch SHALL abandon any outstanding request; late imem_ack SHALL be ignored while in IDLE.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: taken with target_pc[1:0]!=0 sets misalign_err=1, clears instr_valid, enters HALT (no requests) until reset.
REQ-033 Macro undefined: pc<={target_pc[31:2],2'b00}; misalign_err tied 0; HALT unreachable.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the state encodings, RESET_PC default, and OP field bounds (31, 26).
REQ-035 Sub-module branch_resolve SHALL implement REQ-016 combinationally.

Verification
REQ-036 Reset release, imem_ack one cycle after each req, instr_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; one instr_valid pulse per two cycles.
REQ-037 instr_ready=0 for 5 cycles -> instr_valid held high, instr stable, imem_req=0 throughout.
REQ-038 beq (branch_en=1, branch_type=1, zero=1), target 0x00400100, in HOLD -> instr_valid drops next cycle, next imem_addr=0x00400100; same with zero=0 -> no redirect.
REQ-039 Redirect to 0x00400200 while req pending with ack delayed 3 cycles -> req held at old address, returned word discarded, then imem_addr=0x00400200.
REQ-040 Redirect to 0x00400102: macro defined -> misalign_err=1, no further req; undefined -> fetch from 0x00400100.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
